// File: rtl/clkgen_pkg.sv
// Shared types and default widths for the programmable clock generator.
package clkgen_pkg;

    // Per-channel FSM state.
    typedef enum logic [2:0] {
        StIdle,
        StPhase,
        StHigh,
        StLow,
        StDone
    } clkgen_state_e;

    localparam int unsigned CLKGEN_CNT_W  = 16;
    localparam int unsigned CLKGEN_EDGE_W = 32;

endpackage

// File: rtl/clkgen_channel.sv
// One clock-generator channel: phase delay (CLKGEN_PHASE_EN), HIGH/LOW timing,
// burst counting and a wrapping rising-edge counter. All outputs are registered.
module clkgen_channel
    import clkgen_pkg::*;
#(
    parameter int unsigned CNT_W  = CLKGEN_CNT_W,
    parameter int unsigned EDGE_W = CLKGEN_EDGE_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic [CNT_W-1:0]  high_cnt,
    input  logic [CNT_W-1:0]  low_cnt,
    input  logic [CNT_W-1:0]  burst_len,
`ifdef CLKGEN_PHASE_EN
    input  logic [CNT_W-1:0]  phase_cnt,
`endif
    output logic              clk_out,
    output logic [EDGE_W-1:0] rising_edge_count,
    output logic              busy,
    output logic              done
);

    localparam logic [CNT_W-1:0]  CntOne  = CNT_W'(1);
    localparam logic [EDGE_W-1:0] EdgeOne = EDGE_W'(1);

    clkgen_state_e     state_q, state_d;
    logic [CNT_W-1:0]  timer_q, timer_d;
    logic [CNT_W-1:0]  high_q, high_d;
    logic [CNT_W-1:0]  low_q, low_d;
    logic [CNT_W-1:0]  burst_len_q, burst_len_d;
    logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
    logic [EDGE_W-1:0] edge_q, edge_d;
    logic              clk_out_q, clk_out_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // Next-state, timer reload, configuration latch and registered-output decode.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        high_d      = high_q;
        low_d       = low_q;
        burst_len_d = burst_len_q;
        burst_cnt_d = burst_cnt_q;
        edge_d      = edge_q;

        if (stop) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        // Zero durations are stored as 1 so the timer reload never underflows.
                        high_d      = (high_cnt == '0) ? CntOne : high_cnt;
                        low_d       = (low_cnt == '0) ? CntOne : low_cnt;
                        burst_len_d = burst_len;
                        burst_cnt_d = '0;
                        edge_d      = '0;
                        state_d     = StHigh;
                        timer_d     = high_d - CntOne;
`ifdef CLKGEN_PHASE_EN
                        if (phase_cnt != '0) begin
                            state_d = StPhase;
                            timer_d = phase_cnt - CntOne;
                        end
`endif
                    end
                end
                StPhase: begin
                    if (timer_q == '0) begin
                        state_d = StHigh;
                        timer_d = high_q - CntOne;
                    end else begin
                        timer_d = timer_q - CntOne;
                    end
                end
                StHigh: begin
                    if (timer_q == '0) begin
                        state_d = StLow;
                        timer_d = low_q - CntOne;
                    end else begin
                        timer_d = timer_q - CntOne;
                    end
                end
                StLow: begin
                    if (timer_q == '0) begin
                        if (burst_len_q != '0 && burst_cnt_q == burst_len_q) begin
                            state_d = StDone;
                        end else begin
                            state_d = StHigh;
                            timer_d = high_q - CntOne;
                        end
                    end else begin
                        timer_d = timer_q - CntOne;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        // Count the edge in the same cycle clk_out goes high.
        if (state_d == StHigh && state_q != StHigh) begin
            edge_d      = edge_d + EdgeOne;
            burst_cnt_d = burst_cnt_d + CntOne;
        end

        clk_out_d = (state_d == StHigh);
        busy_d    = (state_d == StPhase) || (state_d == StHigh) || (state_d == StLow);
        done_d    = (state_d == StDone) && (state_q != StDone);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            timer_q     <= '0;
            high_q      <= '0;
            low_q       <= '0;
            burst_len_q <= '0;
            burst_cnt_q <= '0;
            edge_q      <= '0;
            clk_out_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            high_q      <= high_d;
            low_q       <= low_d;
            burst_len_q <= burst_len_d;
            burst_cnt_q <= burst_cnt_d;
            edge_q      <= edge_d;
            clk_out_q   <= clk_out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign clk_out           = clk_out_q;
    assign rising_edge_count = edge_q;
    assign busy              = busy_q;
    assign done              = done_q;

endmodule

// File: rtl/prog_clock_gen.sv
// Multi-channel programmable clock generator: NUM_CH independent clkgen_channel
// instances on sliced buses. Define CLKGEN_PHASE_EN to enable the start phase delay.
module prog_clock_gen
    import clkgen_pkg::*;
#(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned CNT_W  = CLKGEN_CNT_W,
    parameter int unsigned EDGE_W = CLKGEN_EDGE_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        start,
    input  logic [NUM_CH-1:0]        stop,
    input  logic [NUM_CH*CNT_W-1:0]  high_cnt,
    input  logic [NUM_CH*CNT_W-1:0]  low_cnt,
    input  logic [NUM_CH*CNT_W-1:0]  burst_len,
    input  logic [NUM_CH*CNT_W-1:0]  phase_cnt,
    output logic [NUM_CH-1:0]        clk_out,
    output logic [NUM_CH*EDGE_W-1:0] rising_edge_count,
    output logic [NUM_CH-1:0]        busy,
    output logic [NUM_CH-1:0]        done
);

`ifndef CLKGEN_PHASE_EN
    logic unused_phase;
    assign unused_phase = ^phase_cnt;
`endif

    // One channel per bus slice.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clkgen_channel #(
            .CNT_W  (CNT_W),
            .EDGE_W (EDGE_W)
        ) u_ch (
            .clk               (clk),
            .rst_n             (rst_n),
            .start             (start[i]),
            .stop              (stop[i]),
            .high_cnt          (high_cnt[i*CNT_W +: CNT_W]),
            .low_cnt           (low_cnt[i*CNT_W +: CNT_W]),
            .burst_len         (burst_len[i*CNT_W +: CNT_W]),
`ifdef CLKGEN_PHASE_EN
            .phase_cnt         (phase_cnt[i*CNT_W +: CNT_W]),
`endif
            .clk_out           (clk_out[i]),
            .rising_edge_count (rising_edge_count[i*EDGE_W +: EDGE_W]),
            .busy              (busy[i]),
            .done              (done[i])
        );
    end

endmodule

// File: tb/tb_prog_clock_gen.sv
// Scoreboard bench for prog_clock_gen: stimulus pushes expected rise/done events,
// a negedge monitor pops and compares them. Honours CLKGEN_PHASE_EN.
module tb_prog_clock_gen;

    typedef struct {
        int cyc;
        int cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  start, stop;
    logic [31:0] high_cnt, low_cnt, burst_len, phase_cnt;
    logic [1:0]  clk_out, busy, done;
    logic [63:0] edge_cnt;

    logic        start4, stop4;
    logic [15:0] high4, low4, burst4, phase4;
    logic        clk_out4, busy4, done4;
    logic [3:0]  edge4;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    logic [2:0] prev = '0;

    exp_t rise_q0[$], rise_q1[$], rise_q2[$];
    int   done_q0[$], done_q1[$], done_q2[$];

    prog_clock_gen #(.NUM_CH(2), .CNT_W(16), .EDGE_W(32)) u_dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .stop              (stop),
        .high_cnt          (high_cnt),
        .low_cnt           (low_cnt),
        .burst_len         (burst_len),
        .phase_cnt         (phase_cnt),
        .clk_out           (clk_out),
        .rising_edge_count (edge_cnt),
        .busy              (busy),
        .done              (done)
    );

    prog_clock_gen #(.NUM_CH(1), .CNT_W(16), .EDGE_W(4)) u_dut4 (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start4),
        .stop              (stop4),
        .high_cnt          (high4),
        .low_cnt           (low4),
        .burst_len         (burst4),
        .phase_cnt         (phase4),
        .clk_out           (clk_out4),
        .rising_edge_count (edge4),
        .busy              (busy4),
        .done              (done4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic cfg(input int ch, input int hi, input int lo, input int bl, input int ph);
        high_cnt[ch*16 +: 16]  = 16'(hi);
        low_cnt[ch*16 +: 16]   = 16'(lo);
        burst_len[ch*16 +: 16] = 16'(bl);
        phase_cnt[ch*16 +: 16] = 16'(ph);
    endtask

    function automatic exp_t mk(input int c, input int n);
        exp_t e;
        e.cyc = c;
        e.cnt = n;
        return e;
    endfunction

    // Monitor side: pop the expected event for each observed rise or done pulse.
    task automatic mon_rise(input int ch, input int cnt);
        exp_t e;
        bit   empty;
        case (ch)
            0: begin empty = (rise_q0.size() == 0); if (!empty) e = rise_q0.pop_front(); end
            1: begin empty = (rise_q1.size() == 0); if (!empty) e = rise_q1.pop_front(); end
            default: begin
                empty = (rise_q2.size() == 0);
                if (!empty) e = rise_q2.pop_front();
            end
        endcase
        checks++;
        if (empty) begin
            errors++;
            $display("FAIL unexpected_rise ch%0d: got rise at cycle %0d expected none", ch, cyc);
        end else begin
            chk($sformatf("rise_cycle ch%0d", ch), cyc, e.cyc);
            chk($sformatf("rise_count ch%0d", ch), cnt, e.cnt);
        end
    endtask

    task automatic mon_done(input int ch);
        int  c;
        bit  empty;
        case (ch)
            0: begin empty = (done_q0.size() == 0); if (!empty) c = done_q0.pop_front(); end
            1: begin empty = (done_q1.size() == 0); if (!empty) c = done_q1.pop_front(); end
            default: begin
                empty = (done_q2.size() == 0);
                if (!empty) c = done_q2.pop_front();
            end
        endcase
        checks++;
        if (empty) begin
            errors++;
            $display("FAIL unexpected_done ch%0d: got done at cycle %0d expected none", ch, cyc);
        end else begin
            chk($sformatf("done_cycle ch%0d", ch), cyc, c);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (clk_out[0] && !prev[0]) mon_rise(0, int'(edge_cnt[31:0]));
            if (clk_out[1] && !prev[1]) mon_rise(1, int'(edge_cnt[63:32]));
            if (clk_out4 && !prev[2])   mon_rise(2, int'(edge4));
            if (done[0]) mon_done(0);
            if (done[1]) mon_done(1);
            if (done4)   mon_done(2);
        end
        prev <= {clk_out4, clk_out};
    end

    initial begin
        int s;
        int ph_off;
        rst_n = 1'b0;
        start = '0; stop = '0;
        high_cnt = '0; low_cnt = '0; burst_len = '0; phase_cnt = '0;
        start4 = 1'b0; stop4 = 1'b0;
        high4 = '0; low4 = '0; burst4 = '0; phase4 = '0;
        repeat (3) tick();

        chk("reset clk_out", clk_out, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset count", edge_cnt, 0);
        rst_n = 1'b1;
        tick();
        mon_en = 1'b1;

        // ch0 free-running 3/7, ch1 burst 4 of 2/2, both started together.
        s = cyc;
        cfg(0, 3, 7, 0, 0);
        cfg(1, 2, 2, 4, 0);
        rise_q0.push_back(mk(s + 1, 1));
        rise_q0.push_back(mk(s + 11, 2));
        rise_q0.push_back(mk(s + 21, 3));
        for (int k = 0; k < 4; k++) rise_q1.push_back(mk(s + 1 + 4 * k, k + 1));
        done_q1.push_back(s + 17);
        start = 2'b11;
        tick();
        start = 2'b00;
        chk("busy after start", busy, 2'b11);
        // Restart attempt with new config while busy must change nothing.
        wait_until(s + 5);
        cfg(0, 1, 1, 0, 0);
        start = 2'b01;
        tick();
        start = 2'b00;
        wait_until(s + 18);
        chk("burst busy after done", busy[1], 0);
        chk("burst clk_out after done", clk_out[1], 0);
        chk("burst count held", edge_cnt[63:32], 4);
        chk("done single pulse", done[1], 0);
        wait_until(s + 25);
        stop = 2'b01;
        tick();
        stop = 2'b00;
        chk("stop clk_out", clk_out[0], 0);
        chk("stop busy", busy[0], 0);
        chk("stop count held", edge_cnt[31:0], 3);

        // high=0, low=0 behaves as 1/1.
        s = cyc;
        cfg(0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) rise_q0.push_back(mk(s + 1 + 2 * k, k + 1));
        start = 2'b01;
        tick();
        start = 2'b00;
        chk("min period high", clk_out[0], 1);
        tick();
        chk("min period low", clk_out[0], 0);
        tick();
        chk("min period high again", clk_out[0], 1);
        wait_until(s + 7);
        stop = 2'b01;
        tick();
        stop = 2'b00;
        chk("min period count held", edge_cnt[31:0], 4);

        // stop wins over simultaneous start mid-HIGH.
        s = cyc;
        cfg(0, 4, 4, 0, 0);
        rise_q0.push_back(mk(s + 1, 1));
        start = 2'b01;
        tick();
        start = 2'b00;
        wait_until(s + 2);
        stop = 2'b01;
        start = 2'b01;
        tick();
        stop = 2'b00;
        start = 2'b00;
        chk("stop+start clk_out", clk_out[0], 0);
        chk("stop+start busy", busy[0], 0);
        chk("stop+start count", edge_cnt[31:0], 1);
        chk("stop+start done", done[0], 0);
        repeat (3) tick();
        chk("stop+start stays idle", busy[0], 0);

        // Reset mid-burst on both channels.
        s = cyc;
        cfg(0, 2, 2, 10, 0);
        cfg(1, 2, 2, 10, 0);
        rise_q0.push_back(mk(s + 1, 1));
        rise_q0.push_back(mk(s + 5, 2));
        rise_q1.push_back(mk(s + 1, 1));
        rise_q1.push_back(mk(s + 5, 2));
        start = 2'b11;
        tick();
        start = 2'b00;
        wait_until(s + 6);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid reset clk_out", clk_out, 0);
        chk("mid reset busy", busy, 0);
        chk("mid reset done", done, 0);
        chk("mid reset count", edge_cnt, 0);
        repeat (20) tick();
        chk("after reset idle", busy, 0);

        // Phase delay: 5 cycles of low before the first rise when enabled.
`ifdef CLKGEN_PHASE_EN
        ph_off = 5;
`else
        ph_off = 0;
`endif
        s = cyc;
        cfg(0, 2, 2, 1, 5);
        rise_q0.push_back(mk(s + 1 + ph_off, 1));
        done_q0.push_back(s + 5 + ph_off);
        start = 2'b01;
        tick();
        start = 2'b00;
        chk("phase busy", busy[0], 1);
        chk("phase clk_out first cycle", clk_out[0], (ph_off == 0) ? 1 : 0);
        wait_until(s + 14);
        chk("phase burst finished", busy[0], 0);
        chk("phase count", edge_cnt[31:0], 1);

        // 4-bit edge counter wraps 15 -> 0 on the 16th rise.
        s = cyc;
        high4 = 16'd1; low4 = 16'd1; burst4 = 16'd0;
        for (int k = 0; k < 17; k++) rise_q2.push_back(mk(s + 1 + 2 * k, (k + 1) % 16));
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        wait_until(s + 34);
        stop4 = 1'b1;
        tick();
        stop4 = 1'b0;
        chk("wrap count held", edge4, 1);
        chk("wrap busy", busy4, 0);

        repeat (4) tick();
        chk("pending rises ch0", rise_q0.size(), 0);
        chk("pending rises ch1", rise_q1.size(), 0);
        chk("pending rises w4", rise_q2.size(), 0);
        chk("pending done ch0", done_q0.size(), 0);
        chk("pending done ch1", done_q1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/prog_clock_gen.md
PROG_CLOCK_GEN -- requirements
Module: prog_clock_gen

Interface
REQ-001 The block SHALL expose parameter NUM_CH, default 2, number of independent clock channels (1..8).
REQ-002 The block SHALL expose parameter CNT_W, default 16, width of the phase, high, low and burst counters.
REQ-003 The block SHALL expose parameter EDGE_W, default 32, width of each rising-edge counter.
REQ-004 Ports (name direction width meaning):
- clk  in  1  sole clock; all logic on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  NUM_CH  per-channel start pulse.
- stop  in  NUM_CH  per-channel synchronous abort.
- high_cnt  in  NUM_CH*CNT_W  HIGH duration in clk cycles.
- low_cnt  in  NUM_CH*CNT_W  LOW duration in clk cycles.
- burst_len  in  NUM_CH*CNT_W  rising edges to generate; 0 means free-running.
- phase_cnt  in  NUM_CH*CNT_W  initial delay; used only with CLKGEN_PHASE_EN.
- clk_out  out  NUM_CH  generated clocks, registered.
- rising_edge_count  out  NUM_CH*EDGE_W  rising edges since the last start.
- busy  out  NUM_CH  channel is running.
- done  out  NUM_CH  one-cycle pulse when a burst completes.

Function
REQ-005 Each channel SHALL run an independent FSM with states IDLE, PHASE, HIGH, LOW and DONE.
REQ-006 When start[i] is sampled high in IDLE or DONE, the channel SHALL latch high_cnt, low_cnt, burst_len and phase_cnt, clear its edge counter, and leave that state on the next edge.
REQ-007 Entry SHALL go to PHASE if CLKGEN_PHASE_EN is defined and the latched phase_cnt is nonzero; otherwise it SHALL go to HIGH.
REQ-008 A HIGH count or LOW count of 0 SHALL be treated as 1, so the minimum period is 2 clk cycles.
REQ-009 clk_out[i] SHALL be 1 for exactly the latched high count of cycles in HIGH and 0 for exactly the latched low count of cycles in LOW, giving period = high + low.
REQ-010 The first clk_out rise SHALL occur in the cycle after start is sampled, plus the phase delay when enabled.
REQ-011 rising_edge_count[i] SHALL increment in the same cycle that clk_out[i] transitions 0->1, and SHALL wrap modulo 2^EDGE_W.
REQ-012 With burst_len = N > 0, the channel SHALL go to DONE after the LOW phase of the Nth cycle, pulse done[i] for one cycle, hold clk_out = 0, and hold the count at N.
REQ-013 With burst_len = 0, the channel SHALL run until stop is asserted.
REQ-014 start asserted while busy SHALL be ignored, and input changes while busy SHALL have no effect until the next start.
REQ-015 stop[i] asserted in any state SHALL, on the next edge, force IDLE with clk_out = 0 and done = 0 while holding the count; stop SHALL win over a simultaneous start.
REQ-016 busy[i] SHALL be 1 in PHASE, HIGH and LOW, and 0 otherwise.

Reset
REQ-017 When rst_n = 0 at a clk edge, every channel SHALL go to IDLE and clk_out, rising_edge_count, busy and done SHALL all be 0.
REQ-018 Reset mid-burst SHALL abort the burst without a done pulse.
REQ-019 Latched configuration SHALL be cleared to 0 at reset.

Configuration
REQ-020 Macro CLKGEN_PHASE_EN defined SHALL enable the PHASE state: clk_out is held at 0 for the latched phase_cnt cycles before the first HIGH.
REQ-021 Without CLKGEN_PHASE_EN, the PHASE state, phase_cnt latch and phase counter SHALL be absent, phase_cnt SHALL be ignored, and HIGH SHALL follow start directly.

Structure
REQ-022 Package clkgen_pkg SHALL hold the FSM state typedef (IDLE, PHASE, HIGH, LOW, DONE) and the default CNT_W and EDGE_W constants.
REQ-023 Sub-module clkgen_channel SHALL implement one channel, and prog_clock_gen SHALL instantiate NUM_CH copies with a generate loop and slice the buses.

Verification
REQ-024 high=3, low=7, burst=0, start on ch0 -> period 10, clk_out high 3 cycles, count 1,2,3 at cycles 1,11,21 after start.
REQ-025 high=2, low=2, burst=4 -> four pulses, then done pulse 1 cycle, busy=0, count=4, clk_out stays 0.
REQ-026 high=0, low=0 -> period 2, 50% duty.
REQ-027 stop and start together mid-HIGH -> IDLE next cycle, clk_out=0, count held, no done pulse.
REQ-028 rst_n=0 during a burst on both channels -> all outputs 0 next edge; with CLKGEN_PHASE_EN, phase=5 -> first rise 6 cycles after start.
REQ-029 EDGE_W=4, free-running -> count wraps from 15 to 0 on the 16th rise.
